// File: rtl/crossbar_pkg.sv
// Shared definitions for the crossbar A/D-channel arbiter.
//   - FSM state encoding for the arbiter
//   - TileLink-UL field widths and opcode values
//   - Address map: chip ids plus region base/size constants
//   - in_region(): helper that tests whether an address falls in a region
package crossbar_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StResp
  } arb_state_e;

  // TileLink-UL field widths
  localparam int unsigned OPCODE_W = 3;
  localparam int unsigned PARAM_W  = 3;
  localparam int unsigned SIZE_W   = 3;
  localparam int unsigned SOURCE_W = 4;
  localparam int unsigned ADDR_W   = 64;
  localparam int unsigned MASK_W   = 8;
  localparam int unsigned DATA_W   = 64;
  localparam int unsigned CHIP_W   = 6;

  // TileLink-UL opcodes
  localparam logic [OPCODE_W-1:0] TL_A_PUT_FULL        = 3'd0;
  localparam logic [OPCODE_W-1:0] TL_A_PUT_PARTIAL     = 3'd1;
  localparam logic [OPCODE_W-1:0] TL_A_GET             = 3'd4;
  localparam logic [OPCODE_W-1:0] TL_D_ACCESS_ACK      = 3'd0;
  localparam logic [OPCODE_W-1:0] TL_D_ACCESS_ACK_DATA = 3'd1;

  // Chip ids driven on chip_sel
  localparam logic [CHIP_W-1:0] CHIP_NONE  = 6'd0;
  localparam logic [CHIP_W-1:0] CHIP_ROM   = 6'd1;
  localparam logic [CHIP_W-1:0] CHIP_CLINT = 6'd2;
  localparam logic [CHIP_W-1:0] CHIP_PLIC  = 6'd3;
  localparam logic [CHIP_W-1:0] CHIP_UART  = 6'd4;
  localparam logic [CHIP_W-1:0] CHIP_DRAM  = 6'd5;

  // ROM decodes from 0x1000 but its offsets are taken relative to 0x0,
  // so its window start and its base differ.
  localparam logic [ADDR_W-1:0] ROM_LO     = 64'h0000_0000_0000_1000;
  localparam logic [ADDR_W-1:0] ROM_SIZE   = 64'h0000_0000_0000_F000;
  localparam logic [ADDR_W-1:0] ROM_BASE   = 64'h0000_0000_0000_0000;
  localparam logic [ADDR_W-1:0] CLINT_BASE = 64'h0000_0000_0200_0000;
  localparam logic [ADDR_W-1:0] CLINT_SIZE = 64'h0000_0000_0001_0000;
  localparam logic [ADDR_W-1:0] PLIC_BASE  = 64'h0000_0000_0C00_0000;
  localparam logic [ADDR_W-1:0] PLIC_SIZE  = 64'h0000_0000_0400_0000;
  localparam logic [ADDR_W-1:0] UART_BASE  = 64'h0000_0000_1000_0000;
  localparam logic [ADDR_W-1:0] UART_SIZE  = 64'h0000_0000_0000_1000;
  localparam logic [ADDR_W-1:0] DRAM_BASE  = 64'h0000_0000_8000_0000;
  localparam logic [ADDR_W-1:0] DRAM_SIZE  = 64'h0000_0000_8000_0000;

  // Subtract-then-compare avoids overflow of lo + size at the top of memory.
  function automatic logic in_region(input logic [ADDR_W-1:0] addr,
                                     input logic [ADDR_W-1:0] lo,
                                     input logic [ADDR_W-1:0] size);
    return (addr >= lo) && ((addr - lo) < size);
  endfunction

endpackage

// File: rtl/crossbar_addr_decode.sv
// Combinational address decoder for the crossbar.
// Maps an A-channel address onto a target chip id and an offset
// inside that target.
//   addr_i      : A-channel address
//   chip_sel_o  : chip id (CHIP_NONE when the address is unmapped)
//   chip_addr_o : address minus the region base (the raw address when unmapped)
module crossbar_addr_decode
  import crossbar_pkg::*;
(
  input  logic [ADDR_W-1:0] addr_i,
  output logic [CHIP_W-1:0] chip_sel_o,
  output logic [ADDR_W-1:0] chip_addr_o
);

  always_comb begin
    chip_sel_o  = CHIP_NONE;
    chip_addr_o = addr_i;
    if (in_region(addr_i, ROM_LO, ROM_SIZE)) begin
      chip_sel_o  = CHIP_ROM;
      chip_addr_o = addr_i - ROM_BASE;
    end else if (in_region(addr_i, CLINT_BASE, CLINT_SIZE)) begin
      chip_sel_o  = CHIP_CLINT;
      chip_addr_o = addr_i - CLINT_BASE;
    end else if (in_region(addr_i, PLIC_BASE, PLIC_SIZE)) begin
      chip_sel_o  = CHIP_PLIC;
      chip_addr_o = addr_i - PLIC_BASE;
    end else if (in_region(addr_i, UART_BASE, UART_SIZE)) begin
      chip_sel_o  = CHIP_UART;
      chip_addr_o = addr_i - UART_BASE;
    end else if (in_region(addr_i, DRAM_BASE, DRAM_SIZE)) begin
      chip_sel_o  = CHIP_DRAM;
      chip_addr_o = addr_i - DRAM_BASE;
    end
  end

endmodule

// File: rtl/crossbar_a_arbiter.sv
// Round-robin arbiter that shares one TileLink-UL A/D channel pair between
// NUM_MASTERS requesters, with a single outstanding transaction at a time.
//   m_a_*      : per-master A channels (fields packed into flat vectors)
//   s_a_*      : granted A channel toward the crossbar, plus chip_sel/chip_addr
//   s_d_*      : D channel from the crossbar
//   m_d_*      : D fields broadcast to all masters; m_d_valid/m_d_ready per master
//   busy       : high when the arbiter is not idle
//   err_flags  : sticky errors; bit0 response timeout, bit1 D source mismatch
module crossbar_a_arbiter
  import crossbar_pkg::*;
#(
  parameter int unsigned NUM_MASTERS    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned IDX_W          = $clog2(NUM_MASTERS)
) (
  input  logic                            clk,
  input  logic                            rst_n,
  // Master A channels
  input  logic [NUM_MASTERS-1:0]          m_a_valid,
  output logic [NUM_MASTERS-1:0]          m_a_ready,
  input  logic [NUM_MASTERS*OPCODE_W-1:0] m_a_opcode,
  input  logic [NUM_MASTERS*PARAM_W-1:0]  m_a_param,
  input  logic [NUM_MASTERS*SIZE_W-1:0]   m_a_size,
  input  logic [NUM_MASTERS*SOURCE_W-1:0] m_a_source,
  input  logic [NUM_MASTERS*ADDR_W-1:0]   m_a_address,
  input  logic [NUM_MASTERS*MASK_W-1:0]   m_a_mask,
  input  logic [NUM_MASTERS*DATA_W-1:0]   m_a_data,
  input  logic [NUM_MASTERS-1:0]          m_a_corrupt,
  // Crossbar A channel
  output logic                            s_a_valid,
  input  logic                            s_a_ready,
  output logic [OPCODE_W-1:0]             s_a_opcode,
  output logic [PARAM_W-1:0]              s_a_param,
  output logic [SIZE_W-1:0]               s_a_size,
  output logic [SOURCE_W-1:0]             s_a_source,
  output logic [ADDR_W-1:0]               s_a_address,
  output logic [MASK_W-1:0]               s_a_mask,
  output logic [DATA_W-1:0]               s_a_data,
  output logic                            s_a_corrupt,
  output logic [CHIP_W-1:0]               chip_sel,
  output logic [ADDR_W-1:0]               chip_addr,
  // Crossbar D channel
  input  logic                            s_d_valid,
  output logic                            s_d_ready,
  input  logic [OPCODE_W-1:0]             s_d_opcode,
  input  logic [SIZE_W-1:0]               s_d_size,
  input  logic [SOURCE_W-1:0]             s_d_source,
  input  logic [DATA_W-1:0]               s_d_data,
  input  logic                            s_d_denied,
  input  logic                            s_d_corrupt,
  // Master D channels
  output logic [NUM_MASTERS-1:0]          m_d_valid,
  input  logic [NUM_MASTERS-1:0]          m_d_ready,
  output logic [OPCODE_W-1:0]             m_d_opcode,
  output logic [SIZE_W-1:0]               m_d_size,
  output logic [SOURCE_W-1:0]             m_d_source,
  output logic [DATA_W-1:0]               m_d_data,
  output logic                            m_d_denied,
  output logic                            m_d_corrupt,
  // Status
  output logic                            busy,
  output logic [1:0]                      err_flags
);

  // One extra count above TIMEOUT_CYCLES-1 so the saturated value is distinct
  // from the cycle that raises the timeout.
  localparam int unsigned          TIMER_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TIMER_W-1:0]   TIMER_MAX  = TIMER_W'(TIMEOUT_CYCLES);
  localparam logic [TIMER_W-1:0]   TIMER_LAST = TIMER_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]     LAST_RESET = IDX_W'(NUM_MASTERS - 1);

  arb_state_e          state_q, state_d;
  logic [IDX_W-1:0]    grant_q, grant_d;
  logic [IDX_W-1:0]    last_grant_q, last_grant_d;
  logic [SOURCE_W-1:0] src_q, src_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic [1:0]          err_q, err_d;

  logic [IDX_W-1:0]    rr_pick;

  logic                gnt_valid;
  logic [OPCODE_W-1:0] gnt_opcode;
  logic [PARAM_W-1:0]  gnt_param;
  logic [SIZE_W-1:0]   gnt_size;
  logic [SOURCE_W-1:0] gnt_source;
  logic [ADDR_W-1:0]   gnt_address;
  logic [MASK_W-1:0]   gnt_mask;
  logic [DATA_W-1:0]   gnt_data;
  logic                gnt_corrupt;

  logic                d_hs;

  // Round-robin pick: first valid requester after last_grant, wrapping.
  always_comb begin
    logic        found;
    int unsigned cand;
    found   = 1'b0;
    cand    = 0;
    rr_pick = '0;
    for (int unsigned i = 1; i <= NUM_MASTERS; i++) begin
      cand = (32'(last_grant_q) + i) % NUM_MASTERS;
      if (!found && m_a_valid[cand]) begin
        found   = 1'b1;
        rr_pick = IDX_W'(cand);
      end
    end
  end

  // A-channel fields of the currently granted master.
  always_comb begin
    int unsigned gi;
    gi          = 32'(grant_q);
    gnt_valid   = m_a_valid[gi];
    gnt_opcode  = m_a_opcode[gi*OPCODE_W +: OPCODE_W];
    gnt_param   = m_a_param[gi*PARAM_W +: PARAM_W];
    gnt_size    = m_a_size[gi*SIZE_W +: SIZE_W];
    gnt_source  = m_a_source[gi*SOURCE_W +: SOURCE_W];
    gnt_address = m_a_address[gi*ADDR_W +: ADDR_W];
    gnt_mask    = m_a_mask[gi*MASK_W +: MASK_W];
    gnt_data    = m_a_data[gi*DATA_W +: DATA_W];
    gnt_corrupt = m_a_corrupt[gi];
  end

  // Fields are forced to zero outside REQ so idle outputs are quiet.
  always_comb begin
    s_a_opcode  = '0;
    s_a_param   = '0;
    s_a_size    = '0;
    s_a_source  = '0;
    s_a_address = '0;
    s_a_mask    = '0;
    s_a_data    = '0;
    s_a_corrupt = 1'b0;
    if (state_q == StReq) begin
      s_a_opcode  = gnt_opcode;
      s_a_param   = gnt_param;
      s_a_size    = gnt_size;
      s_a_source  = gnt_source;
      s_a_address = gnt_address;
      s_a_mask    = gnt_mask;
      s_a_data    = gnt_data;
      s_a_corrupt = gnt_corrupt;
    end
  end

  // Address zero is unmapped, so idle outputs decode to chip 0 / offset 0.
  crossbar_addr_decode u_addr_decode (
    .addr_i      (s_a_address),
    .chip_sel_o  (chip_sel),
    .chip_addr_o (chip_addr)
  );

  assign m_d_opcode  = s_d_opcode;
  assign m_d_size    = s_d_size;
  assign m_d_source  = s_d_source;
  assign m_d_data    = s_d_data;
  assign m_d_denied  = s_d_denied;
  assign m_d_corrupt = s_d_corrupt;

  assign busy      = (state_q != StIdle);
  assign err_flags = err_q;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    src_d        = src_q;
    timer_d      = timer_q;
    err_d        = err_q;
    s_a_valid    = 1'b0;
    m_a_ready    = '0;
    s_d_ready    = 1'b0;
    m_d_valid    = '0;
    d_hs         = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (|m_a_valid) begin
          grant_d = rr_pick;
          state_d = StReq;
        end
      end

      StReq: begin
        s_a_valid          = gnt_valid;
        m_a_ready[grant_q] = s_a_ready;
        if (gnt_valid && s_a_ready) begin
          src_d   = gnt_source;
          timer_d = '0;
          state_d = StResp;
        end else if (!gnt_valid) begin
          // Requester withdrew before the handshake: give up its turn.
          last_grant_d = grant_q;
          state_d      = StIdle;
        end
      end

      StResp: begin
        m_d_valid[grant_q] = s_d_valid;
        s_d_ready          = m_d_ready[grant_q];
        d_hs               = s_d_valid && m_d_ready[grant_q];
        if (d_hs) begin
          last_grant_d = grant_q;
          state_d      = StIdle;
          if (s_d_source != src_q) begin
            err_d[1] = 1'b1;
          end
        end else begin
          if (timer_q == TIMER_LAST) begin
            err_d[0] = 1'b1;
          end
          if (timer_q != TIMER_MAX) begin
            timer_d = timer_q + TIMER_W'(1);
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      grant_q      <= '0;
      last_grant_q <= LAST_RESET;
      src_q        <= '0;
      timer_q      <= '0;
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      src_q        <= src_d;
      timer_q      <= timer_d;
      err_q        <= err_d;
    end
  end

endmodule

// File: doc/crossbar_a_arbiter.md
Name: crossbar_a_arbiter

Overview:
Shares the single TileLink-UL A/D channel pair in front of the crossbar datapath between NUM_MASTERS requesters. It uses round-robin arbitration and allows one outstanding transaction. It decodes the granted A address into chip_sel/chip_addr for the crossbar, returns the D response to the granted master, and flags response timeouts and source mismatches.

Parameters:
NUM_MASTERS, 2, number of A-channel requesters (2..4)
TIMEOUT_CYCLES, 1024, number of cycles in RESP without a D handshake before timeout_err is set
IDX_W, $clog2(NUM_MASTERS), width of the grant index

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
m_a_valid / m_a_ready  in / out  N  per-master A handshake
m_a_opcode, m_a_param, m_a_size  in  3N each  per-master A fields
m_a_source  in  4N  per-master A source
m_a_address  in  64N  per-master A address
m_a_mask  in  8N  per-master A mask
m_a_data  in  64N  per-master A data
m_a_corrupt  in  N  per-master A corrupt
s_a_valid  out  1  A valid to crossbar
s_a_ready  in  1  A ready from crossbar
s_a_opcode, s_a_param, s_a_size, s_a_source, s_a_address, s_a_mask, s_a_data, s_a_corrupt  out  3/3/3/4/64/8/64/1  granted master's A fields
chip_sel  out  6  decoded target chip
chip_addr  out  64  address offset within the target
s_d_valid / s_d_ready  in / out  1  D handshake from crossbar
s_d_opcode, s_d_size, s_d_source, s_d_data, s_d_denied, s_d_corrupt  in  3/3/4/64/1/1  D fields
m_d_valid / m_d_ready  out / in  N  per-master D handshake
m_d_opcode, m_d_size, m_d_source, m_d_data, m_d_denied, m_d_corrupt  out  as s_d_*  D fields, broadcast to all masters
busy  out  1  high when the FSM is not in IDLE
err_flags  out  2  sticky errors: bit0 timeout, bit1 D source mismatch

Behaviour:
- Reset:
  - State IDLE, grant=0, last_grant=NUM_MASTERS-1 so master 0 wins first, timer=0, err_flags=0.
  - All valid/ready outputs are 0 and all s_a_* fields, chip_sel and chip_addr are 0 while in IDLE.
  - Reset mid-transaction aborts it silently; in-flight D is not forwarded.
- FSM states: IDLE, REQ, RESP.
- IDLE:
  - If any m_a_valid is high, register grant = first requester searching from last_grant+1 with wrap-around, then go to REQ.
  - Arbitration costs 1 cycle. No m_a_ready is given in IDLE.
- REQ:
  - s_a_valid = m_a_valid[grant].
  - s_a_* fields are muxed combinationally from the granted master.
  - m_a_ready[grant] = s_a_ready; all other m_a_ready are 0.
  - On s_a_valid & s_a_ready: latch the source, clear the timer, go to RESP.
  - If m_a_valid[grant] drops before the handshake (protocol violation), return to IDLE with last_grant=grant.
  - A fields must stay stable while stalled; they are passed through as-is.
- RESP:
  - m_d_valid[grant] = s_d_valid and s_d_ready = m_d_ready[grant]; other masters see m_d_valid=0.
  - m_d_* fields are always driven from s_d_*.
  - On the D handshake: last_grant=grant, go to IDLE.
  - New arbitration starts the next cycle, so the minimum transaction is 3 cycles.
- s_d_ready is 0 outside RESP, so D beats stall there.
- Single-beat only: every A and D handshake is one complete message. a_size > 3 is forwarded unchecked.
- Timeout:
  - The timer increments every RESP cycle without a D handshake and saturates.
  - When timer == TIMEOUT_CYCLES-1 and no handshake occurs, set err_flags[0]. The FSM stays in RESP.
  - A D handshake in the same cycle wins: no error is set.
- Source mismatch: a D handshake with s_d_source != latched source is still forwarded and sets err_flags[1].
- err_flags clear only on reset.
- Address decode (combinational from s_a_address; valid only when s_a_valid):
  - chip 1 ROM 0x1000..0xFFFF, base 0x0
  - chip 2 CLINT 0x0200_0000 + 64KiB
  - chip 3 PLIC 0x0C00_0000 + 64MiB
  - chip 4 UART 0x1000_0000 + 4KiB
  - chip 5 DRAM 0x8000_0000 + 2GiB
  - chip_addr = address - base, with 64-bit unsigned subtraction.
  - Unmapped addresses give chip_sel=0 and chip_addr=address; the crossbar's error slave answers them.

Decomposition:
- Package crossbar_pkg holds:
  - the state enum (IDLE/REQ/RESP);
  - the region base/size/chip-id constants and the CHIP_* ids;
  - the TileLink opcode constants;
  - the A/D field widths.
- Sub-module crossbar_addr_decode holds the pure combinational region table: address in, chip_sel/chip_addr out.

Test Plan:
- Master 0 sends PutFull to 0x1000_0008 with s_a_ready=1 -> s_a_valid 1 cycle after m_a_valid, chip_sel=4, chip_addr=0x8. D AccessAck is routed only to m_d_valid[0]. busy falls the cycle after the D handshake.
- Masters 0 and 1 hold valid continuously -> grant order is 0,1,0,1. m_a_ready is never high for both masters in the same cycle.
- s_a_ready held low 3 cycles in REQ -> s_a_* is stable and m_a_ready[grant]=0. The handshake occurs on the 4th cycle.
- TIMEOUT_CYCLES=16, no D response -> err_flags[0] rises after 16 RESP cycles and stays set. A late D is still delivered and the FSM returns to IDLE.
- Get to 0x4000_0000 (unmapped) -> chip_sel=0, chip_addr=0x4000_0000. A D response whose s_d_source differs from the A source sets err_flags[1].
- rst_n asserted during RESP -> all outputs 0 immediately and err_flags=0. The next simultaneous request from masters 0 and 1 grants master 0.
